// File: rtl/breakout_pkg.sv
// Shared types and helpers for the Breakout coin/credit block.
// Holds the credit width, the debouncer and coin-meter state encodings,
// and the saturating clamp used by the credit arithmetic.
package breakout_pkg;

   localparam int CREDIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      ACCEPT,
      WAIT_RELEASE
   } coin_state_t;

   typedef enum logic [1:0] {
      M_IDLE,
      M_PULSE,
      M_GAP
   } meter_state_t;

   // Clamp a signed intermediate credit total into 0..limit so the count
   // never wraps on underflow or overflow.
   function automatic logic [CREDIT_W-1:0] clamp_credits(
      input logic signed [5:0]    value,
      input logic [CREDIT_W-1:0]  limit
   );
      logic signed [5:0] limit_s;
      limit_s = $signed({2'b00, limit});
      if (value < 6'sd0) begin
         return '0;
      end else if (value > limit_s) begin
         return limit;
      end else begin
         return value[CREDIT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin chute: 2-flop synchroniser followed by a debounce FSM.
// A chute must read low for DEBOUNCE_CYCLES+1 consecutive samples before a
// single-cycle strobe is raised; the switch must then read high for
// DEBOUNCE_CYCLES samples before another coin can be seen, so a held
// switch counts exactly once.
module coin_debounce
   import breakout_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic coin_n,
   output logic strobe
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   coin_state_t      state;
   logic [CNT_W-1:0] count;

   // Bring the raw, asynchronous chute switch into the clock domain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= coin_n;
         sync_b <= sync_a;
      end
   end

   // Debounce FSM with a registered one-cycle accept strobe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         strobe <= 1'b0;
      end else begin
         strobe <= 1'b0;
         case (state)
            IDLE: begin
               if (!sync_b) begin
                  state <= DEBOUNCE;
                  count <= '0;
               end
            end
            DEBOUNCE: begin
               if (sync_b) begin
                  state <= IDLE;
               end else if (count == LAST) begin
                  state  <= ACCEPT;
                  strobe <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            ACCEPT: begin
               state <= WAIT_RELEASE;
               count <= '0;
            end
            WAIT_RELEASE: begin
               if (!sync_b) begin
                  count <= '0;
               end else if (count == LAST) begin
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/credit_control.sv
// Breakout coin/credit bookkeeping.
// Debounces both chutes, keeps a saturating credit count with a
// coins-per-credit fraction, debits credits on 1- or 2-credit starts that
// arrive while in attract mode, decodes the credit-status lines for
// game_control, and drives a queued coin-meter pulse output.
// Optional feature: define BREAKOUT_FREE_PLAY_EN for free play (credits
// pinned at MAX_CREDITS, both status lines active, debits ignored).
module credit_control
   import breakout_pkg::*;
#(
   parameter int MAX_CREDITS      = 9,
   parameter int COINS_PER_CREDIT = 1,
   parameter int DEBOUNCE_CYCLES  = 1024,
   parameter int METER_CYCLES     = 4096
) (
   input  logic                CLK_DRV,
   input  logic                RESET_N,
   input  logic                COIN1_N,
   input  logic                COIN2_N,
   input  logic                _1_CR_START_N,
   input  logic                _2_CR_START,
   input  logic                ATTRACT,
   output logic                COIN_ACCEPT_N,
   output logic                _1_OR_2_CREDIT_N,
   output logic                _2_CREDIT_N,
   output logic [CREDIT_W-1:0] CREDITS,
   output logic                COIN_METER
);

   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);
   localparam logic [3:0] CPC1 = 4'(COINS_PER_CREDIT);
   localparam logic [3:0] CPC2 = 4'(2 * COINS_PER_CREDIT);
   localparam int MCNT_W = $clog2(METER_CYCLES) + 1;
   localparam logic [MCNT_W-1:0] M_LAST = MCNT_W'(METER_CYCLES - 1);

   logic strobe1;
   logic strobe2;

   logic start1_r;
   logic start1_prev;
   logic start2_r;
   logic start2_prev;
   logic attract_r;
   logic attract_prev;
   logic debit1;
   logic debit2;

   logic [1:0]          coin_count;
   logic [3:0]          frac;
   logic [3:0]          frac_sum;
   logic [3:0]          frac_next;
   logic [1:0]          adds;
   logic [1:0]          debits;
   logic signed [5:0]   credit_sum;
   logic [CREDIT_W-1:0] credit_next;
   logic                one_next;
   logic                two_next;

   meter_state_t        meter_state;
   logic [MCNT_W-1:0]   meter_count;
   logic [1:0]          queue;
   logic [1:0]          queue_next;
   logic [2:0]          queue_sum;
   logic                dequeue;

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_chute1 (
      .clk     (CLK_DRV),
      .reset_n (RESET_N),
      .coin_n  (COIN1_N),
      .strobe  (strobe1)
   );

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_chute2 (
      .clk     (CLK_DRV),
      .reset_n (RESET_N),
      .coin_n  (COIN2_N),
      .strobe  (strobe2)
   );

   assign COIN_ACCEPT_N = ~(strobe1 | strobe2);

   // Register the game_control start/attract lines and keep one cycle of
   // history for edge detection; history is preset inactive so reset
   // release can never look like a start.
   always_ff @(posedge CLK_DRV) begin
      if (!RESET_N) begin
         start1_r     <= 1'b1;
         start1_prev  <= 1'b1;
         start2_r     <= 1'b0;
         start2_prev  <= 1'b0;
         attract_r    <= 1'b0;
         attract_prev <= 1'b0;
      end else begin
         start1_r     <= _1_CR_START_N;
         start1_prev  <= start1_r;
         start2_r     <= _2_CR_START;
         start2_prev  <= start2_r;
         attract_r    <= ATTRACT;
         attract_prev <= attract_r;
      end
   end

   // A start only costs credits if the game was still in attract mode the
   // cycle before, so a start seen mid-game is ignored.
   assign debit1 = start1_prev & ~start1_r & attract_prev;
   assign debit2 = ~start2_prev & start2_r & attract_prev;

   // Coin fraction, credit add/debit netting and status decode of the
   // next credit value.
   always_comb begin
      coin_count = {1'b0, strobe1} + {1'b0, strobe2};
      frac_sum   = frac + {2'b00, coin_count};
      adds       = 2'd0;
      frac_next  = frac_sum;
      if (frac_sum >= CPC2) begin
         adds      = 2'd2;
         frac_next = frac_sum - CPC2;
      end else if (frac_sum >= CPC1) begin
         adds      = 2'd1;
         frac_next = frac_sum - CPC1;
      end
      debits     = {1'b0, debit1} + {debit2, 1'b0};
      credit_sum = $signed({2'b00, CREDITS})
                 + $signed({4'b0000, adds})
                 - $signed({4'b0000, debits});
`ifdef BREAKOUT_FREE_PLAY_EN
      credit_next = MAX_C;
      one_next    = 1'b0;
      two_next    = 1'b0;
`else
      credit_next = clamp_credits(credit_sum, MAX_C);
      one_next    = (credit_next == '0);
      two_next    = (credit_next < CREDIT_W'(2));
`endif
   end

   // Credit count, coin fraction and the status lines update together so
   // the status lines never lag the count.
   always_ff @(posedge CLK_DRV) begin
      if (!RESET_N) begin
         CREDITS          <= '0;
         frac             <= '0;
         _1_OR_2_CREDIT_N <= 1'b1;
         _2_CREDIT_N      <= 1'b1;
      end else begin
         CREDITS          <= credit_next;
         frac             <= frac_next;
         _1_OR_2_CREDIT_N <= one_next;
         _2_CREDIT_N      <= two_next;
      end
   end

   // Meter queue arithmetic: add accepted coins, remove one when a pulse
   // is launched, saturate at 3 (excess coins are lost to the meter only).
   always_comb begin
      dequeue    = (meter_state == M_IDLE) && (queue != 2'd0);
      queue_sum  = {1'b0, queue} + {1'b0, coin_count} - {2'b00, dequeue};
      queue_next = (queue_sum > 3'd3) ? 2'd3 : queue_sum[1:0];
   end

   // Pending meter pulses.
   always_ff @(posedge CLK_DRV) begin
      if (!RESET_N) begin
         queue <= 2'd0;
      end else begin
         queue <= queue_next;
      end
   end

   // Meter sequencer: a pulse of METER_CYCLES followed by an equal gap so
   // the electromechanical counter can follow back-to-back coins.
   always_ff @(posedge CLK_DRV) begin
      if (!RESET_N) begin
         meter_state <= M_IDLE;
         meter_count <= '0;
         COIN_METER  <= 1'b0;
      end else begin
         case (meter_state)
            M_IDLE: begin
               if (queue != 2'd0) begin
                  meter_state <= M_PULSE;
                  meter_count <= '0;
                  COIN_METER  <= 1'b1;
               end
            end
            M_PULSE: begin
               if (meter_count == M_LAST) begin
                  meter_state <= M_GAP;
                  meter_count <= '0;
                  COIN_METER  <= 1'b0;
               end else begin
                  meter_count <= meter_count + 1'b1;
               end
            end
            M_GAP: begin
               if (meter_count == M_LAST) begin
                  meter_state <= M_IDLE;
                  meter_count <= '0;
               end else begin
                  meter_count <= meter_count + 1'b1;
               end
            end
            default: begin
               meter_state <= M_IDLE;
               meter_count <= '0;
               COIN_METER  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_credit_control.sv
// Self-checking bench for credit_control (default build, free play off).
// A fast instance (DEBOUNCE_CYCLES=8, METER_CYCLES=4) carries most checks;
// a second instance with a long meter pulse shares the same inputs so the
// meter queue can be driven into saturation.
module tb_credit_control;

   localparam int MAX_C   = 9;
   localparam int CPC     = 1;
   localparam int DC      = 8;
   localparam int MC      = 4;
   localparam int MC_SLOW = 256;
   localparam int SETTLE  = 60;

   typedef enum int {T_COIN1, T_COIN2, T_BOTH, T_START1, T_START2} txn_t;

   typedef struct {
      txn_t kind;
      logic attract;
      int   credits;
      int   n1;
      int   n2;
      int   accepts;
      int   rises;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       coin1_n;
   logic       coin2_n;
   logic       start1_n;
   logic       start2;
   logic       attract;
   logic       accept_n;
   logic       credit_n1;
   logic       credit_n2;
   logic [3:0] credits;
   logic       meter;
   logic       slow_accept_n;
   logic       slow_n1;
   logic       slow_n2;
   logic [3:0] slow_credits;
   logic       slow_meter;

   int checks = 0;
   int errors = 0;

   int   accept_count = 0;
   int   meter_rises  = 0;
   int   slow_rises   = 0;
   logic meter_prev   = 1'b0;
   logic slow_prev    = 1'b0;

   int model_credits;
   int model_frac;

   always #5 clk = ~clk;

   credit_control #(
      .MAX_CREDITS(MAX_C), .COINS_PER_CREDIT(CPC),
      .DEBOUNCE_CYCLES(DC), .METER_CYCLES(MC)
   ) dut (
      .CLK_DRV(clk), .RESET_N(reset_n), .COIN1_N(coin1_n), .COIN2_N(coin2_n),
      ._1_CR_START_N(start1_n), ._2_CR_START(start2), .ATTRACT(attract),
      .COIN_ACCEPT_N(accept_n), ._1_OR_2_CREDIT_N(credit_n1),
      ._2_CREDIT_N(credit_n2), .CREDITS(credits), .COIN_METER(meter)
   );

   credit_control #(
      .MAX_CREDITS(MAX_C), .COINS_PER_CREDIT(CPC),
      .DEBOUNCE_CYCLES(DC), .METER_CYCLES(MC_SLOW)
   ) dut_slow (
      .CLK_DRV(clk), .RESET_N(reset_n), .COIN1_N(coin1_n), .COIN2_N(coin2_n),
      ._1_CR_START_N(start1_n), ._2_CR_START(start2), .ATTRACT(attract),
      .COIN_ACCEPT_N(slow_accept_n), ._1_OR_2_CREDIT_N(slow_n1),
      ._2_CREDIT_N(slow_n2), .CREDITS(slow_credits), .COIN_METER(slow_meter)
   );

   // Count accept pulses and meter pulses on the falling edge.
   always @(negedge clk) begin
      if (!accept_n) accept_count <= accept_count + 1;
      if (meter && !meter_prev) meter_rises <= meter_rises + 1;
      if (slow_meter && !slow_prev) slow_rises <= slow_rises + 1;
      meter_prev <= meter;
      slow_prev  <= slow_meter;
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset_n  = 1'b0;
      coin1_n  = 1'b1;
      coin2_n  = 1'b1;
      start1_n = 1'b1;
      start2   = 1'b0;
      attract  = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic checkStatus(input string tag, input int exp_credits);
      checkOutput({tag, "_credits"}, int'(credits), exp_credits);
      checkOutput({tag, "_n1"}, int'(credit_n1), (exp_credits >= 1) ? 0 : 1);
      checkOutput({tag, "_n2"}, int'(credit_n2), (exp_credits >= 2) ? 0 : 1);
   endtask

   // One clean transaction followed by enough idle time to settle.
   task automatic applyStimulus(input txn_t kind, input logic att);
      attract = att;
      repeat (4) tick();
      case (kind)
         T_COIN1, T_COIN2, T_BOTH: begin
            coin1_n = (kind == T_COIN2);
            coin2_n = (kind == T_COIN1);
            repeat (DC + 6) tick();
            coin1_n = 1'b1;
            coin2_n = 1'b1;
            repeat (SETTLE) tick();
         end
         T_START1: begin
            start1_n = 1'b0;
            repeat (2) tick();
            start1_n = 1'b1;
            repeat (4) tick();
         end
         default: begin
            start2 = 1'b1;
            repeat (2) tick();
            start2 = 1'b0;
            repeat (4) tick();
         end
      endcase
   endtask

   // Reference model: coins feed a fraction that converts to credits and
   // saturates; starts in attract mode subtract and floor at zero.
   task automatic modelUpdate(input txn_t kind, input logic att);
      int coins;
      coins = (kind == T_BOTH) ? 2 : ((kind == T_COIN1 || kind == T_COIN2) ? 1 : 0);
      model_frac    = model_frac + coins;
      model_credits = model_credits + model_frac / CPC;
      model_frac    = model_frac % CPC;
      if (model_credits > MAX_C) model_credits = MAX_C;
      if (att && kind == T_START1) model_credits = model_credits - 1;
      if (att && kind == T_START2) model_credits = model_credits - 2;
      if (model_credits < 0) model_credits = 0;
   endtask

   initial begin
      vec_t vecs[9];
      int   a0, r0, s0;
      int   acc_tick, acc_lows, cred_tick, m_first, m_high;
      int   c_before, c_after;
      logic m_trace[80];
      int   run_a, run_b, run_c, run_d, rises;
      bit   found;
      txn_t kind;
      logic att;
      int   coins;

      doReset();

      // Reset values.
      checkOutput("reset_credits", int'(credits), 0);
      checkOutput("reset_accept_n", int'(accept_n), 1);
      checkOutput("reset_n1", int'(credit_n1), 1);
      checkOutput("reset_n2", int'(credit_n2), 1);
      checkOutput("reset_meter", int'(meter), 0);

      // Single coin: latency = 2 sync + DEBOUNCE_CYCLES+1, credit one cycle
      // later, meter launched from the queue one cycle after that.
      acc_tick = -1; acc_lows = 0; cred_tick = -1; m_first = -1; m_high = 0;
      coin1_n = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (!accept_n) begin
            acc_lows++;
            if (acc_tick < 0) acc_tick = t;
         end
         if (credits == 4'd1 && cred_tick < 0) cred_tick = t;
         if (meter) begin
            m_high++;
            if (m_first < 0) m_first = t;
         end
         if (t == 20) coin1_n = 1'b1;
      end
      checkOutput("coin_accept_tick", acc_tick, DC + 3);
      checkOutput("coin_accept_lows", acc_lows, 1);
      checkOutput("coin_credit_tick", cred_tick, DC + 4);
      checkOutput("coin_meter_first", m_first, DC + 5);
      checkOutput("coin_meter_high", m_high, MC);
      checkStatus("coin", 1);

      // Bounce: two short lows separated by a one-cycle high never accept.
      a0 = accept_count;
      coin1_n = 1'b0; repeat (5) tick();
      coin1_n = 1'b1; tick();
      coin1_n = 1'b0; repeat (5) tick();
      coin1_n = 1'b1; repeat (SETTLE) tick();
      checkOutput("bounce_accepts", accept_count - a0, 0);
      checkStatus("bounce", 1);

      // Simultaneous coins: 0 -> 2 in a single cycle, two meter pulses.
      doReset();
      a0 = accept_count;
      c_before = -1; c_after = -1;
      coin1_n = 1'b0;
      coin2_n = 1'b0;
      for (int t = 1; t <= 80; t++) begin
         tick();
         if (t == DC + 3) c_before = int'(credits);
         if (t == DC + 4) c_after = int'(credits);
         m_trace[t-1] = meter;
         if (t == 20) begin
            coin1_n = 1'b1;
            coin2_n = 1'b1;
         end
      end
      checkOutput("sim_credits_before", c_before, 0);
      checkOutput("sim_credits_after", c_after, 2);
      checkOutput("sim_accept_lows", accept_count - a0, 1);
      run_a = -1; run_b = -1; run_c = -1; run_d = -1; rises = 0;
      for (int i = 1; i < 80; i++) begin
         if (m_trace[i] && !m_trace[i-1]) begin
            rises++;
            if (run_a < 0) run_a = i;
            else if (run_c < 0) run_c = i;
         end
         if (!m_trace[i] && m_trace[i-1]) begin
            if (run_b < 0) run_b = i;
            else if (run_d < 0) run_d = i;
         end
      end
      checkOutput("sim_meter_rises", rises, 2);
      checkOutput("sim_pulse1_len", run_b - run_a, MC);
      checkOutput("sim_pulse2_len", run_d - run_c, MC);
      checkOutput("sim_gap_in_range",
                  int'((run_c - run_b) >= MC && (run_c - run_b) <= MC + 1), 1);

      // Table of transactions with hand-computed outcomes.
      vecs[0] = '{T_COIN1,  1'b1, 1, 0, 1, 1, 1};
      vecs[1] = '{T_COIN2,  1'b1, 2, 0, 0, 1, 1};
      vecs[2] = '{T_COIN1,  1'b1, 3, 0, 0, 1, 1};
      vecs[3] = '{T_START2, 1'b1, 1, 0, 1, 0, 0};
      vecs[4] = '{T_START1, 1'b0, 1, 0, 1, 0, 0};
      vecs[5] = '{T_START1, 1'b1, 0, 1, 1, 0, 0};
      vecs[6] = '{T_COIN2,  1'b0, 1, 0, 1, 1, 1};
      vecs[7] = '{T_START2, 1'b1, 0, 1, 1, 0, 0};
      vecs[8] = '{T_BOTH,   1'b1, 2, 0, 0, 1, 2};
      doReset();
      for (int v = 0; v < 9; v++) begin
         a0 = accept_count;
         r0 = meter_rises;
         applyStimulus(vecs[v].kind, vecs[v].attract);
         checkOutput($sformatf("vec%0d_credits", v), int'(credits), vecs[v].credits);
         checkOutput($sformatf("vec%0d_n1", v), int'(credit_n1), vecs[v].n1);
         checkOutput($sformatf("vec%0d_n2", v), int'(credit_n2), vecs[v].n2);
         checkOutput($sformatf("vec%0d_accepts", v), accept_count - a0, vecs[v].accepts);
         checkOutput($sformatf("vec%0d_rises", v), meter_rises - r0, vecs[v].rises);
      end

      // Randomised transactions against the reference model.
      model_credits = 2;
      model_frac    = 0;
      for (int i = 0; i < 30; i++) begin
         kind  = txn_t'($urandom_range(0, 4));
         att   = 1'($urandom_range(0, 1));
         coins = (kind == T_BOTH) ? 2 : ((kind == T_COIN1 || kind == T_COIN2) ? 1 : 0);
         a0 = accept_count;
         r0 = meter_rises;
         applyStimulus(kind, att);
         modelUpdate(kind, att);
         checkStatus($sformatf("rnd%0d", i), model_credits);
         checkOutput($sformatf("rnd%0d_accepts", i), accept_count - a0, (coins > 0) ? 1 : 0);
         checkOutput($sformatf("rnd%0d_rises", i), meter_rises - r0, coins);
      end

      // Saturation: 12 coins in quick pairs; credits stop at MAX_C, the
      // slow meter launches one pulse and queues only three more.
      doReset();
      r0 = meter_rises;
      s0 = slow_rises;
      for (int p = 0; p < 6; p++) begin
         coin1_n = 1'b0;
         coin2_n = 1'b0;
         repeat (DC + 4) tick();
         coin1_n = 1'b1;
         coin2_n = 1'b1;
         repeat (DC + 6) tick();
      end
      checkStatus("sat", MAX_C);
      checkOutput("sat_slow_credits", int'(slow_credits), MAX_C);
      checkOutput("sat_slow_n1", int'(slow_n1), 0);
      checkOutput("sat_slow_n2", int'(slow_n2), 0);
      repeat (4 * (2 * MC_SLOW + 1) + 40) tick();
      checkOutput("sat_fast_rises", meter_rises - r0, 12);
      checkOutput("sat_slow_rises", slow_rises - s0, 4);
      s0 = slow_rises;
      coin1_n = 1'b0;
      repeat (DC + 6) tick();
      coin1_n = 1'b1;
      repeat (40) tick();
      checkOutput("sat_after_drain_rises", slow_rises - s0, 1);
      checkOutput("sat_after_drain_credits", int'(credits), MAX_C);
      checkOutput("sat_slow_accept_n", int'(slow_accept_n), 1);

      // Reset while a meter pulse is in progress with five credits.
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(T_COIN1, 1'b1);
      coin1_n = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
         tick();
         if (meter) found = 1'b1;
      end
      checkOutput("midpulse_meter_seen", int'(found), 1);
      checkOutput("midpulse_credits_before", int'(credits), 5);
      reset_n = 1'b0;
      coin1_n = 1'b1;
      tick();
      checkOutput("midpulse_credits", int'(credits), 0);
      checkOutput("midpulse_meter", int'(meter), 0);
      checkOutput("midpulse_n1", int'(credit_n1), 1);
      checkOutput("midpulse_n2", int'(credit_n2), 1);
      checkOutput("midpulse_accept_n", int'(accept_n), 1);
      reset_n = 1'b1;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
